// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared loader state encoding and byte-index constants
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_DATA  = 3'd1,
        ST_CHK   = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } ld_state_e;

    localparam int          BYTE_IDX_W    = 2;
    localparam logic [1:0]  BYTE_IDX_LAST = 2'd3;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// rtl/prog_loader_word_assembler.sv - little-endian byte-to-word assembler with one-cycle word_valid pulse
module prog_loader_word_assembler
    import prog_loader_pkg::*;
(
    input  logic        CLK,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [31:0]           word_q, word_d;
    logic                  word_valid_q, word_valid_d;

    // Merge the incoming byte at its lane; the completed word stays on word_q during the strobe cycle
    always_comb begin
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear) begin
            byte_idx_d = '0;
        end else if (byte_valid) begin
            if (byte_idx_q == '0) begin
                word_d = {24'd0, byte_data};
            end else begin
                word_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
            end
            word_valid_d = (byte_idx_q == BYTE_IDX_LAST);
            byte_idx_d   = byte_idx_q + 2'd1;
        end
    end

    // Assembler state; reset discards any partial word
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            byte_idx_q   <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word       = word_q;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader FSM writing a byte-stream image into instruction memory (option: PROG_LOADER_CHECKSUM_EN)
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    ld_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic           rx_ready_q, rx_ready_d;
    logic           cpu_hold_q, cpu_hold_d;
    logic           load_done_q, load_done_d;
    logic           load_err_q, load_err_d;

    logic           accept;
    logic           hdr_bad;
    logic           timer_exp;
    logic           last_word;
    logic           word_valid;
    logic [31:0]    word;

    assign accept    = rx_valid && rx_ready_q;
    assign hdr_bad   = (rx_data == 8'd0) || ({24'd0, rx_data} > (32'd1 << ADDR_W));
    assign timer_exp = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
    assign last_word = ((words_q + CNT_W'(1)) == count_q);

    prog_loader_word_assembler u_asm (
        .CLK        (CLK),
        .rst        (rst),
        .clear      (state_q == ST_HDR),
        .byte_valid (accept && (state_q == ST_DATA)),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Running XOR over payload bytes only; cleared when a header is taken
    always_comb begin
        csum_d = csum_q;
        if (accept && (state_q == ST_HDR)) begin
            csum_d = 8'd0;
        end else if (accept && (state_q == ST_DATA)) begin
            csum_d = csum_q ^ rx_data;
        end
    end

    // Checksum register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            csum_q <= 8'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // Next-state, counters and registered status outputs derived from the next state
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        words_d = words_q;
        timer_d = timer_q;
        case (state_q)
            ST_HDR: begin
                timer_d = '0;
                if (accept) begin
                    if (hdr_bad) begin
                        state_d = ST_ERROR;
                    end else begin
                        count_d = CNT_W'(rx_data);
                        words_d = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // An accepted byte always beats an expiring timer
                if (accept) begin
                    timer_d = '0;
                end else if (timer_exp) begin
                    state_d = ST_ERROR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
                if (word_valid) begin
                    words_d = words_q + CNT_W'(1);
                    if (last_word) begin
                        timer_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_RUN;
`endif
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    timer_d = '0;
                    state_d = (rx_data == csum_q) ? ST_RUN : ST_ERROR;
                end else if (timer_exp) begin
                    state_d = ST_ERROR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
`endif
            ST_RUN, ST_ERROR: begin
                if (reload) begin
                    state_d = ST_HDR;
                end
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase

        rx_ready_d  = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CHK);
        cpu_hold_d  = (state_d != ST_RUN);
        load_done_d = (state_d == ST_RUN);
        load_err_d  = (state_d == ST_ERROR);
    end

    // Loader state and registered outputs
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HDR;
            count_q     <= '0;
            words_q     <= '0;
            timer_q     <= '0;
            rx_ready_q  <= 1'b1;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            words_q     <= words_d;
            timer_q     <= timer_d;
            rx_ready_q  <= rx_ready_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_we      = word_valid;
    assign imem_addr    = words_q[ADDR_W-1:0];
    assign imem_wdata   = word;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_q;

endmodule
